bram_reader: RTL and testbench

BRAM_READER -- requirements
Module: bram_reader

---
 rtl/bram_reader_pkg.sv | 17 +
 rtl/bram_reader_skid_fifo2.sv | 57 +++++
 rtl/bram_reader.sv | 122 ++++++++++++
 tb/tb_bram_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_reader_pkg.sv
// rtl/bram_reader_pkg.sv - shared state encoding, buffer depth and address helper for bram_reader
package bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

  // Next word address, wrapping at lim-1 back to zero for non power-of-two depths.
  function automatic logic [31:0] wrap_inc(input logic [31:0] a, input logic [31:0] lim);
    return (a == lim - 32'd1) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/bram_reader_skid_fifo2.sv
// rtl/bram_reader_skid_fifo2.sv - two-entry read-data buffer between the memory and the downstream port
module skid_fifo2
  import bram_reader_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [width-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [width-1:0] o_rd_data,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [width-1:0] r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_full    = (r_count == 2'(BUF_DEPTH));
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!w_full || w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bram_reader.sv
// rtl/bram_reader.sv - burst reader: issues sequential BRAM reads and streams the words out in order
module bram_reader
  import bram_reader_pkg::*;
#(
  parameter int width  = 4,
  parameter int depth  = 1024,
  parameter int maxlen = 256,
  localparam int AW = $clog2(depth),
  localparam int CW = $clog2(maxlen + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start__ENA,
  input  logic [AW-1:0]    start_base,
  input  logic [CW-1:0]    start_count,
  output logic             start__RDY,
  output logic             read__ENA,
  output logic [AW-1:0]    read_addr,
  input  logic             read__RDY,
  input  logic [width-1:0] dataOut,
  input  logic             dataOut__RDY,
  output logic             out__ENA,
  output logic [width-1:0] out_data,
  input  logic             out__RDY,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    r_issue;
  logic [CW-1:0]    r_deliver;
  logic             r_inflight;
  logic             r_done;

  logic             w_accept;
  logic             w_pop;
  logic             w_read;
  logic             w_buf_wr;
  logic             w_buf_empty;
  logic [1:0]       w_buf_count;
  logic [2:0]       w_occ_next;
  logic [width-1:0] w_buf_head;

  assign w_accept = start__ENA && (r_state == ST_IDLE);
  assign w_pop    = !w_buf_empty && out__RDY;
  assign w_buf_wr = dataOut__RDY && r_inflight;

  // Words already buffered or in flight, after this cycle's pop, must leave room for one more.
  assign w_occ_next = {1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_read     = (r_state == ST_RUN) && read__RDY && (r_issue != '0)
                      && (w_occ_next < 3'(BUF_DEPTH));

  assign start__RDY = (r_state == ST_IDLE);
  assign read__ENA  = w_read;
  assign read_addr  = r_addr;
  assign out__ENA   = w_pop;
  assign out_data   = w_buf_head;
  assign done       = r_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (start_count != '0)) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_read && (r_issue == CW'(1))) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_pop && (r_deliver == CW'(1))) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_issue    <= '0;
      r_deliver  <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_read;
      r_done     <= (w_accept && (start_count == '0))
                    || (w_pop && (r_deliver == CW'(1)));
      if (w_accept) begin
        r_addr    <= start_base;
        r_issue   <= start_count;
        r_deliver <= start_count;
      end else begin
        if (w_read) begin
          r_addr  <= AW'(wrap_inc(32'(r_addr), 32'(depth)));
          r_issue <= r_issue - CW'(1);
        end
        if (w_pop && (r_deliver != '0)) begin
          r_deliver <= r_deliver - CW'(1);
        end
      end
    end
  end

  skid_fifo2 #(
    .width(width)
  ) u_buf (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_wr_en  (w_buf_wr),
    .i_wr_data(dataOut),
    .i_rd_en  (w_pop),
    .o_rd_data(w_buf_head),
    .o_empty  (w_buf_empty),
    .o_count  (w_buf_count)
  );

  // Read data with no read outstanding means the memory and this block disagree.
  a_no_stray_data: assert property (@(posedge CLK) disable iff (!nRST) dataOut__RDY |-> r_inflight);

endmodule

// File: tb/tb_bram_reader.sv
// tb/tb_bram_reader.sv - directed bench for bram_reader with a one-cycle-latency memory model
module tb_bram_reader;

  logic       CLK;
  logic       nRST;
  logic       start__ENA;
  logic [9:0] start_base;
  logic [8:0] start_count;
  logic       start__RDY;
  logic       read__ENA;
  logic [9:0] read_addr;
  logic       read__RDY;
  logic [3:0] dataOut;
  logic       dataOut__RDY;
  logic       out__ENA;
  logic [3:0] out_data;
  logic       out__RDY;
  logic       done;

  bram_reader dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start__ENA  (start__ENA),
    .start_base  (start_base),
    .start_count (start_count),
    .start__RDY  (start__RDY),
    .read__ENA   (read__ENA),
    .read_addr   (read_addr),
    .read__RDY   (read__RDY),
    .dataOut     (dataOut),
    .dataOut__RDY(dataOut__RDY),
    .out__ENA    (out__ENA),
    .out_data    (out_data),
    .out__RDY    (out__RDY),
    .done        (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [3:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 4'(i);
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dataOut__RDY <= 1'b0;
      dataOut      <= 4'd0;
    end else begin
      dataOut__RDY <= read__ENA && read__RDY;
      dataOut      <= ram[read_addr];
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int cyc = 0;
  int bp_mode = 0;
  int bp_idx = 0;
  int rd_addr[$];
  int out_log[$];
  int out_cyc[$];
  int first_rd_cyc, start_cyc, done_cyc, done_cnt, rdy_low, max_out;

  task automatic clear_log();
    rd_addr.delete();
    out_log.delete();
    out_cyc.delete();
    first_rd_cyc = -1;
    start_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    rdy_low = 0;
    max_out = 0;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    out__RDY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      out__RDY = (bp_mode == 0) || (bp_idx % 3 == 0);
      if (bp_mode != 0) bp_idx++;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (nRST) begin
      if (start__ENA && start__RDY) start_cyc = cyc;
      if (!start__RDY) rdy_low = 1;
      if (read__ENA) begin
        if (rd_addr.size() == 0) first_rd_cyc = cyc;
        rd_addr.push_back(int'(read_addr));
      end
      if (out__ENA) begin
        out_log.push_back(int'(out_data));
        out_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_addr.size() - out_log.size() > max_out) max_out = rd_addr.size() - out_log.size();
    end
  end

  task automatic start_burst(input int base, input int count);
    @(posedge CLK);
    #1;
    start__ENA  = 1'b1;
    start_base  = 10'(base);
    start_count = 9'(count);
    @(posedge CLK);
    #1;
    start__ENA  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    check({tag, "_done_seen"}, done_cnt, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start_rdy"}, int'(start__RDY), 1);
    check({tag, "_read_ena"}, int'(read__ENA), 0);
    check({tag, "_out_ena"}, int'(out__ENA), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_read_addr"}, int'(read_addr), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    nRST        = 1'b0;
    start__ENA  = 1'b0;
    start_base  = '0;
    start_count = '0;
    read__RDY   = 1'b1;
    clear_log();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    nRST = 1'b1;

    // Full-rate burst: addresses 5..8, words on consecutive cycles
    clear_log();
    start_burst(5, 4);
    wait_done("full", 50);
    check("full_nreads", rd_addr.size(), 4);
    check("full_nwords", out_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) check("full_addr", rd_addr[i], 5 + i);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("full_data", out_log[i], 5 + i);
    for (int i = 1; i < 4 && i < out_cyc.size(); i++) check("full_b2b", out_cyc[i] - out_cyc[i-1], 1);
    check("full_first_rd_lat", first_rd_cyc - start_cyc, 1);
    if (out_cyc.size() == 4) begin
      check("full_first_word_lat", out_cyc[0] - first_rd_cyc, 2);
      check("full_done_lat", done_cyc - out_cyc[3], 1);
    end

    // Wrap-around at the top of memory
    clear_log();
    start_burst(1022, 4);
    wait_done("wrap", 50);
    check("wrap_nreads", rd_addr.size(), 4);
    if (rd_addr.size() == 4) begin
      check("wrap_addr0", rd_addr[0], 1022);
      check("wrap_addr1", rd_addr[1], 1023);
      check("wrap_addr2", rd_addr[2], 0);
      check("wrap_addr3", rd_addr[3], 1);
    end
    if (out_log.size() == 4) begin
      check("wrap_data1", out_log[1], 15);
      check("wrap_data2", out_log[2], 0);
    end

    // Backpressure with out__RDY 1,0,0 repeating
    clear_log();
    bp_idx  = 0;
    bp_mode = 1;
    start_burst(100, 8);
    wait_done("bp", 200);
    bp_mode = 0;
    check("bp_nwords", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) check("bp_data", out_log[i], (100 + i) % 16);
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) check("bp_addr", rd_addr[i], 100 + i);
    check("bp_outstanding_le2", int'(max_out <= 2), 1);
    check("bp_outstanding_hit2", max_out, 2);

    // Zero-length burst
    clear_log();
    start_burst(7, 0);
    wait_done("zero", 20);
    check("zero_nreads", rd_addr.size(), 0);
    check("zero_done_lat", done_cyc - start_cyc, 1);
    check("zero_rdy_dropped", rdy_low, 0);

    // Reset after 3 of 8 words, then a fresh 2-word burst from address 0
    clear_log();
    start_burst(200, 8);
    for (int i = 0; i < 50 && out_log.size() < 3; i++) begin
      @(negedge CLK);
      #2;
    end
    check("rst_words_before", out_log.size(), 3);
    nRST = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    clear_log();
    start_burst(0, 2);
    wait_done("rst_new", 50);
    check("rst_new_nwords", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("rst_new_data0", out_log[0], 0);
      check("rst_new_data1", out_log[1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
